// File: rtl/life_pkg.sv
// Shared constants and state encoding for the Life column grid and its loader.
package life_pkg;

    localparam int LIFE_ROWS  = 4;
    localparam int LIFE_ROW_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } life_state_e;

endpackage

// File: rtl/life_loader.sv
// Serial pattern loader and generation run controller for a row of life_col4
// columns. Bits stream in column-major order (column 0 rows 0..3 first) and are
// written through the shared column write port; while idle, run/step gate the
// generation enable. A write and an enable are never active in the same cycle.
module life_loader
    import life_pkg::*;
#(
    parameter int COLS  = 4,
    parameter int COL_W = $clog2(COLS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic                  bit_ready,
    input  logic                  run,
    input  logic                  step,
    output logic                  write_enb,
    output logic                  val,
    output logic [LIFE_ROW_W-1:0] row,
    output logic [COLS-1:0]       col_sel,
    output logic                  enable,
    output logic                  busy,
    output logic                  done
);

    life_state_e           state_q, state_d;
    logic [LIFE_ROW_W-1:0] row_cnt;
    logic [COL_W-1:0]      col_cnt;
    logic                  accept;
    logic                  last_bit;
    logic                  row_last;
    logic                  col_last;

    assign row_last = (row_cnt == LIFE_ROW_W'(LIFE_ROWS - 1));
    assign col_last = (col_cnt == COL_W'(COLS - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state plus the combinational handshake/status outputs.
    always_comb begin
        state_d   = state_q;
        bit_ready = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
                accept    = bit_valid;
                last_bit  = bit_valid && row_last && col_last;
                if (last_bit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Row/column position of the next bit; restarted at every start so a load
    // cut short by reset begins again at column 0, row 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (state_q == ST_IDLE && start) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (accept) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_last) col_cnt <= col_last ? '0 : col_cnt + 1'b1;
        end
    end

    // Registered column write port: one-cycle latency from bit acceptance.
    // Address and value hold through LOAD gaps and clear once back in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_enb <= 1'b0;
            val       <= 1'b0;
            row       <= '0;
            col_sel   <= '0;
        end else if (accept) begin
            write_enb <= 1'b1;
            val       <= bit_in;
            row       <= row_cnt;
            col_sel   <= COLS'(1) << col_cnt;
        end else if (state_q == ST_LOAD) begin
            write_enb <= 1'b0;
        end else begin
            write_enb <= 1'b0;
            val       <= 1'b0;
            row       <= '0;
            col_sel   <= '0;
        end
    end

    // Generation enable and load-complete pulse; start beats run/step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable <= 1'b0;
            done   <= 1'b0;
        end else begin
            enable <= (state_q == ST_IDLE) && !start && (run || step);
            done   <= last_bit;
        end
    end

endmodule

// File: tb/tb_life_loader.sv
// Directed bench for life_loader with a 4-column grid.
module tb_life_loader;

    localparam int COLS = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            bit_in = 1'b0;
    logic            bit_valid = 1'b0;
    logic            run = 1'b0;
    logic            step = 1'b0;
    logic            bit_ready, write_enb, val, enable, busy, done;
    logic [1:0]      row;
    logic [COLS-1:0] col_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    life_loader #(.COLS(COLS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .run       (run),
        .step      (step),
        .write_enb (write_enb),
        .val       (val),
        .row       (row),
        .col_sel   (col_sel),
        .enable    (enable),
        .busy      (busy),
        .done      (done)
    );

    // Advance one clock; outputs are looked at 1 ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [11:0] o;
        reset = 1'b0;
        repeat (2) tick;
        reset = 1'b1;
        run = 1'b1;
        tick;
        run = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        total++;
        if ({busy, bit_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_preload: busy,ready=%b expected 11", {busy, bit_ready});
        end
        #2 reset = 1'b0;
        #1;
        o = {bit_ready, write_enb, val, row, col_sel, enable, busy, done};
        total++;
        if (o !== 12'h0) begin
            bad++;
            $display("FAIL reset_async: outs=%h expected 000", o);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick;
        o = {bit_ready, write_enb, val, row, col_sel, enable, busy, done};
        total++;
        if (o !== 12'h0) begin
            bad++;
            $display("FAIL reset_idle: outs=%h expected 000", o);
        end
    endtask

    task automatic test_full_load;
        logic [15:0] pat = 16'hA5C3;
        logic [3:0]  exp_col;
        logic [1:0]  exp_row;
        int          nw = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        total++;
        if ({busy, bit_ready, enable, write_enb} !== 4'b1100) begin
            bad++;
            $display("FAIL load_start: busy,ready,en,we=%b expected 1100",
                     {busy, bit_ready, enable, write_enb});
        end
        for (int i = 0; i < 16; i++) begin
            bit_valid = 1'b1;
            bit_in = pat[i];
            tick;
            exp_col = 4'b0001 << (i / 4);
            exp_row = 2'(i % 4);
            if (write_enb) nw++;
            total++;
            if ({write_enb, val, row, col_sel, done, busy} !==
                {1'b1, pat[i], exp_row, exp_col, (i == 15), (i != 15)}) begin
                bad++;
                $display("FAIL load_bit%0d: we=%b val=%b row=%0d sel=%b done=%b busy=%b expected val=%b row=%0d sel=%b",
                         i, write_enb, val, row, col_sel, done, busy, pat[i], exp_row, exp_col);
            end
        end
        bit_valid = 1'b0;
        bit_in = 1'b0;
        tick;
        total++;
        if ({write_enb, done, busy, bit_ready, col_sel} !== 8'h00) begin
            bad++;
            $display("FAIL load_after: we,done,busy,ready,sel=%b expected 00000000",
                     {write_enb, done, busy, bit_ready, col_sel});
        end
        total++;
        if (nw !== 16) begin
            bad++;
            $display("FAIL load_count: writes=%0d expected 16", nw);
        end
    endtask

    task automatic test_gapped;
        logic [15:0] pat = 16'h3C96;
        logic [3:0]  exp_col;
        logic [1:0]  exp_row;
        int          nw = 0;
        int          nd = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_col = 4'b0001 << (i / 4);
            exp_row = 2'(i % 4);
            bit_valid = 1'b1;
            bit_in = pat[i];
            tick;
            nw += int'(write_enb);
            nd += int'(done);
            total++;
            if ({write_enb, val, row, col_sel} !== {1'b1, pat[i], exp_row, exp_col}) begin
                bad++;
                $display("FAIL gap_bit%0d: we=%b val=%b row=%0d sel=%b expected val=%b row=%0d sel=%b",
                         i, write_enb, val, row, col_sel, pat[i], exp_row, exp_col);
            end
            if (i < 15) begin
                for (int g = 0; g < 2; g++) begin
                    bit_valid = 1'b0;
                    bit_in = ~pat[i];
                    tick;
                    nw += int'(write_enb);
                    nd += int'(done);
                    total++;
                    if ({write_enb, row, col_sel, busy} !== {1'b0, exp_row, exp_col, 1'b1}) begin
                        bad++;
                        $display("FAIL gap_hold%0d: we=%b row=%0d sel=%b busy=%b expected row=%0d sel=%b",
                                 i, write_enb, row, col_sel, busy, exp_row, exp_col);
                    end
                end
            end
        end
        bit_valid = 1'b0;
        bit_in = 1'b0;
        repeat (3) begin
            tick;
            nw += int'(write_enb);
            nd += int'(done);
        end
        total++;
        if (nw !== 16 || nd !== 1) begin
            bad++;
            $display("FAIL gap_count: writes=%0d dones=%0d expected 16 and 1", nw, nd);
        end
    endtask

    task automatic test_run_step;
        for (int c = 0; c < 5; c++) begin
            run = 1'b1;
            tick;
            total++;
            if (enable !== 1'b1) begin
                bad++;
                $display("FAIL run_cycle%0d: enable=%b expected 1", c, enable);
            end
        end
        run = 1'b0;
        tick;
        total++;
        if (enable !== 1'b0) begin
            bad++;
            $display("FAIL run_stop: enable=%b expected 0", enable);
        end
        step = 1'b1;
        tick;
        step = 1'b0;
        total++;
        if (enable !== 1'b1) begin
            bad++;
            $display("FAIL step_on: enable=%b expected 1", enable);
        end
        tick;
        total++;
        if (enable !== 1'b0) begin
            bad++;
            $display("FAIL step_off: enable=%b expected 0", enable);
        end
        // step while loading must be dropped, not remembered
        start = 1'b1;
        tick;
        start = 1'b0;
        step = 1'b1;
        tick;
        step = 1'b0;
        total++;
        if (enable !== 1'b0) begin
            bad++;
            $display("FAIL step_in_load: enable=%b expected 0", enable);
        end
        for (int i = 0; i < 16; i++) begin
            bit_valid = 1'b1;
            bit_in = i[0];
            tick;
        end
        bit_valid = 1'b0;
        tick;
        total++;
        if ({enable, busy} !== 2'b00) begin
            bad++;
            $display("FAIL step_after_load: enable,busy=%b expected 00", {enable, busy});
        end
    endtask

    task automatic test_priority;
        int en_seen = 0;
        run = 1'b1;
        tick;
        total++;
        if (enable !== 1'b1) begin
            bad++;
            $display("FAIL prio_run: enable=%b expected 1", enable);
        end
        start = 1'b1;
        tick;
        start = 1'b0;
        total++;
        if ({enable, busy} !== 2'b01) begin
            bad++;
            $display("FAIL prio_start: enable,busy=%b expected 01", {enable, busy});
        end
        for (int i = 0; i < 16; i++) begin
            bit_valid = 1'b1;
            bit_in = ~i[1];
            tick;
            en_seen += int'(enable);
        end
        bit_valid = 1'b0;
        total++;
        if ({done, write_enb, en_seen != 0} !== 3'b110) begin
            bad++;
            $display("FAIL prio_load: done=%b we=%b enable_cycles=%0d expected 1 1 0",
                     done, write_enb, en_seen);
        end
        tick;
        total++;
        if (enable !== 1'b1) begin
            bad++;
            $display("FAIL prio_resume: enable=%b expected 1", enable);
        end
        run = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_load;
        logic [11:0] o;
        logic [3:0]  exp_col;
        logic [1:0]  exp_row;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bit_valid = 1'b1;
            bit_in = 1'b1;
            tick;
        end
        #2 reset = 1'b0;
        #1;
        o = {bit_ready, write_enb, val, row, col_sel, enable, busy, done};
        total++;
        if (o !== 12'h0) begin
            bad++;
            $display("FAIL midreset_outs: outs=%h expected 000", o);
        end
        @(negedge clk);
        bit_valid = 1'b0;
        reset = 1'b1;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bit_valid = 1'b1;
            bit_in = 1'b1;
            tick;
            exp_col = 4'b0001 << (i / 4);
            exp_row = 2'(i % 4);
            total++;
            if ({write_enb, row, col_sel, done} !== {1'b1, exp_row, exp_col, (i == 15)}) begin
                bad++;
                $display("FAIL midreset_bit%0d: we=%b row=%0d sel=%b done=%b expected row=%0d sel=%b",
                         i, write_enb, row, col_sel, done, exp_row, exp_col);
            end
        end
        bit_valid = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_full_load;
        test_gapped;
        test_run_step;
        test_priority;
        test_reset_mid_load;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/life_loader.md
# life_loader

Pattern loader and run controller for a grid of 4-row Life columns (`life_col4`). Accepts a serial bit stream over a valid/ready handshake and drives the shared column write port (`write_enb`, `val`, `row`) plus a one-hot column select. It loads an initial pattern column by column, then gates the generation `enable` for free-run or single-step evolution. It sits between the host/pattern source and the column array and is the only driver of the column write and enable inputs.

## Interface
- `COLS`, default 4: number of `life_col4` columns in the grid, ≥2.
- `COL_W`, default `$clog2(COLS)`: column counter width (derived, not overridden).

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: begin loading a full pattern.
- `bit_in`  in  1  pattern bit, 1 = alive.
- `bit_valid`  in  1  `bit_in` is valid.
- `bit_ready`  out  1  loader accepts a bit this cycle.
- `run`  in  1  level: free-run generations while idle.
- `step`  in  1  pulse: advance exactly one generation while idle.
- `write_enb`  out  1  column write strobe.
- `val`  out  1  value written to the addressed cell.
- `row`  out  2  row address within a column, 0 = top.
- `col_sel`  out  COLS  one-hot column select, qualifies `write_enb` per column.
- `enable`  out  1  generation enable to all columns.
- `busy`  out  1  high while in LOAD.
- `done`  out  1  one-cycle pulse when the final pattern bit has been written.

## Operation
- States: IDLE, LOAD. Reset → IDLE.
- Stream order: column 0 rows 0..3, then column 1 rows 0..3, …; total `4*COLS` bits.
- IDLE:
  - `bit_ready` = 0.
  - `start` → LOAD; clear row and column counters.
  - Otherwise `enable` next cycle = `run | step`.
- LOAD:
  - `bit_ready` = 1 and `busy` = 1.
  - On `bit_valid & bit_ready`: register `write_enb` = 1, `val` = `bit_in`, `row` = row counter, `col_sel` = onehot(column counter). Then increment row; on row wrap 3→0, increment column.
  - When the accepted bit is at row 3, column `COLS-1` → IDLE.
  - Cycles without `bit_valid`: `write_enb` = 0, counters hold, `row`/`col_sel` hold their last value.
  - `start` and `step` are ignored; `run` is masked.
- `enable` is forced 0 in LOAD and on the cycle `start` is sampled in IDLE. A write and an enable never coincide.
- `col_sel` is all zeros whenever `write_enb` = 0, except while holding during LOAD gaps; consumers must qualify it with `write_enb`.

## Timing
- Reset values: `bit_ready`=0, `write_enb`=0, `val`=0, `row`=0, `col_sel`=0, `enable`=0, `busy`=0, `done`=0.
- Reset is asynchronous, with clean deassertion assumed synchronized upstream.
- `start` sampled at edge k:
  - `busy` = 1 and `bit_ready` = 1 from k+1.
  - `enable` = 0 from k+1.
- Bit accepted at edge k: `write_enb`/`val`/`row`/`col_sel` valid in cycle k+1, i.e. 1-cycle latency.
- Final bit accepted at edge k:
  - `write_enb` and `done` both high in cycle k+1.
  - `busy` and `bit_ready` low from k+1.
- `run`/`step` sampled at edge k in IDLE: `enable` reflects them in cycle k+1. A 1-cycle `step` gives exactly one `enable` cycle.
- `start` at the same edge as `run`/`step`: `start` wins, and `enable` = 0 next cycle.
- Reset mid-load: the partial pattern stays in the columns. The next `start` restarts at column 0, row 0.

## Structure
- Shared package `life_pkg`:
  - `LIFE_ROWS` = 4.
  - `LIFE_ROW_W` = 2.
  - State encoding constants for IDLE/LOAD.
- Single module with no sub-modules. The one-hot decode of the column counter is inline.

## Test plan
- Reset: assert `reset`=0 mid-cycle → all outputs 0 immediately. Release, idle 3 cycles → outputs still 0.
- Full load, `COLS`=4, `bit_valid` continuous, pattern 16'hA5C3 LSB first:
  - Expect 16 consecutive `write_enb` cycles.
  - (`row`, `col_sel`) sequence: (0,0001)…(3,0001), (0,0010)…(3,1000).
  - `val` follows the pattern bits.
  - `done` pulses with the 16th write; `busy` low after.
- Gapped stream: `bit_valid` toggles 1,0,0,1… → `write_enb` only after accepted bits, counters hold through gaps, still exactly 16 writes and one `done`.
- Free-run and step:
  - `run`=1 for 5 cycles → `enable` high for 5 cycles, lagging by 1.
  - One-cycle `step` → exactly one `enable` cycle.
  - `step` during LOAD → no `enable`.
- Priority: `run`=1 with `start` pulsed → `enable` 0 from the next cycle through the end of LOAD, and high again the cycle after `done` if `run` is still 1.
- Reset mid-load after 6 bits → outputs 0. New `start` plus 16 bits → first write at `row`=0, `col_sel`=0001.
